conv_stream_ctrl: RTL and testbench

Stream-side sequencer that drives the convolution core's load interface and collects its results. It accepts kernel rows and image rows over valid/ready handshakes and generates the core's select strobes and data buses. It captures each completed window's result from the core into a small result FIFO, presented downstream with valid/ready. It sits between the frame memory/DMA and the convolution core, owning the protocol that the core only receives.

---
 rtl/conv_pkg.sv | 14 +
 rtl/conv_res_fifo.sv | 46 ++++
 rtl/conv_stream_ctrl.sv | 118 +++++++++++
 tb/tb_conv_stream_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution stream sequencer.
package conv_pkg;
  localparam int DEF_BIT_LEN  = 8;
  localparam int DEF_M_LEN    = 3;
  localparam int DEF_CONV_LEN = 20;
  localparam int DEF_M_ARRAY  = DEF_BIT_LEN * DEF_M_LEN;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_K = 2'd1,
    LOAD_I = 2'd2,
    DRAIN  = 2'd3
  } state_t;
endpackage

// File: rtl/conv_res_fifo.sv
// Synchronous result FIFO; head reads as zero while empty.
module conv_res_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // a push into a full FIFO is only taken when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

// File: rtl/conv_stream_ctrl.sv
// Sequences kernel/image rows into the convolution core and queues its window results.
module conv_stream_ctrl
  import conv_pkg::*;
#(
  parameter int BIT_LEN   = DEF_BIT_LEN,
  parameter int M_LEN     = DEF_M_LEN,
  parameter int CONV_LEN  = DEF_CONV_LEN,
  parameter int IMG_ROWS  = 5,
  parameter int CONV_LAT  = 1,
  parameter int RES_DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic                      i_reuse_k,
  input  logic                      i_k_valid,
  output logic                      o_k_ready,
  input  logic [BIT_LEN*M_LEN-1:0]  i_k_data,
  input  logic                      i_img_valid,
  output logic                      o_img_ready,
  input  logic [BIT_LEN*M_LEN-1:0]  i_img_data,
  output logic                      o_selec_K,
  output logic                      o_selec_I,
  output logic [BIT_LEN*M_LEN-1:0]  o_data_kernel,
  output logic [BIT_LEN*M_LEN-1:0]  o_data_img,
  input  logic [CONV_LEN-1:0]       i_conv_data,
  output logic                      o_res_valid,
  input  logic                      i_res_ready,
  output logic [CONV_LEN-1:0]       o_res_data,
  output logic                      o_busy,
  output logic                      o_done
);
  localparam int CW = $clog2(IMG_ROWS + 1);
  localparam int FW = $clog2(RES_DEPTH) + 1;
  localparam logic [CW-1:0] K_LAST = CW'(M_LEN - 1);
  localparam logic [CW-1:0] I_LAST = CW'(IMG_ROWS - 1);
  localparam logic [CW-1:0] W_FIRST = CW'(M_LEN - 1);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [CONV_LAT:0] vld_pipe;
  logic            k_loaded, done_nx;
  logic            k_fire, img_fire, win_fire;
  logic            res_empty;
  logic [FW-1:0]   res_cnt, res_free, in_flight;

  // windows in flight must already own a FIFO slot, so the FIFO cannot overflow
  always_comb begin
    in_flight = '0;
    for (int i = 0; i <= CONV_LAT; i++) in_flight = in_flight + FW'(vld_pipe[i]);
  end

  assign res_free    = FW'(RES_DEPTH) - res_cnt;
  assign o_k_ready   = (state == LOAD_K);
  assign o_img_ready = (state == LOAD_I) && (res_free > in_flight);
  assign o_busy      = (state != IDLE);
  assign o_res_valid = ~res_empty;
  assign k_fire      = i_k_valid & o_k_ready;
  assign img_fire    = i_img_valid & o_img_ready;
  assign win_fire    = img_fire && (cnt >= W_FIRST);

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE:    if (i_start) state_nx = (i_reuse_k && k_loaded) ? LOAD_I : LOAD_K;
      LOAD_K:  if (k_fire && cnt == K_LAST) state_nx = LOAD_I;
      LOAD_I:  if (img_fire && cnt == I_LAST) state_nx = DRAIN;
      DRAIN: begin
        if (vld_pipe == '0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      cnt           <= '0;
      vld_pipe      <= '0;
      k_loaded      <= 1'b0;
      o_done        <= 1'b0;
      o_selec_K     <= 1'b0;
      o_selec_I     <= 1'b0;
      o_data_kernel <= '0;
      o_data_img    <= '0;
    end else begin
      state  <= state_nx;
      o_done <= done_nx;
      if (state_nx != state)        cnt <= '0;
      else if (k_fire || img_fire)  cnt <= cnt + 1'b1;
      if (k_fire && cnt == K_LAST)  k_loaded <= 1'b1;
      vld_pipe[0] <= win_fire;
      for (int i = 1; i <= CONV_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      o_selec_K <= k_fire;
      o_selec_I <= img_fire;
      if (k_fire)   o_data_kernel <= i_k_data;
      if (img_fire) o_data_img    <= i_img_data;
    end
  end

  conv_res_fifo #(
    .WIDTH (CONV_LEN),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (vld_pipe[CONV_LAT]),
    .wdata (i_conv_data),
    .pop   (o_res_valid & i_res_ready),
    .rdata (o_res_data),
    .empty (res_empty),
    .count (res_cnt)
  );
endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Directed and randomized frames against a 3x3 core model and a whole-frame reference.
module tb_conv_stream_ctrl;
  import conv_pkg::*;
  localparam int IR  = 5;
  localparam int RD  = 2;
  localparam int NW  = IR - DEF_M_LEN + 1;
  localparam int LIM = 200;

  logic i_clk = 1'b0;
  logic i_reset, i_start, i_reuse_k, i_k_valid, o_k_ready, i_img_valid, o_img_ready;
  logic [DEF_M_ARRAY-1:0] i_k_data, i_img_data, o_data_kernel, o_data_img;
  logic o_selec_K, o_selec_I, o_res_valid, i_res_ready, o_busy, o_done;
  logic [DEF_CONV_LEN-1:0] i_conv_data, o_res_data;

  int errs = 0, checks = 0;
  int rmode = 1;
  int kv[3][3];
  int iv[IR][3];
  logic [DEF_CONV_LEN-1:0] exp_q[$], got_q[$];
  int gi = 0;
  int n_k = 0, n_i = 0, n_done = 0, n_kr = 0, sel_bad = 0;
  logic k_es = 1'b0, i_es = 1'b0;
  logic [DEF_M_ARRAY-1:0] k_ed = '0, i_ed = '0;
  logic [DEF_M_ARRAY-1:0] kw[3], iw[3];

  always #5 i_clk = ~i_clk;

  conv_stream_ctrl #(
    .BIT_LEN(DEF_BIT_LEN), .M_LEN(DEF_M_LEN), .CONV_LEN(DEF_CONV_LEN),
    .IMG_ROWS(IR), .CONV_LAT(1), .RES_DEPTH(RD)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_reuse_k(i_reuse_k),
    .i_k_valid(i_k_valid), .o_k_ready(o_k_ready), .i_k_data(i_k_data),
    .i_img_valid(i_img_valid), .o_img_ready(o_img_ready), .i_img_data(i_img_data),
    .o_selec_K(o_selec_K), .o_selec_I(o_selec_I),
    .o_data_kernel(o_data_kernel), .o_data_img(o_data_img),
    .i_conv_data(i_conv_data), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_data(o_res_data), .o_busy(o_busy), .o_done(o_done)
  );

  function automatic int dot3(input logic [DEF_M_ARRAY-1:0] a, input logic [DEF_M_ARRAY-1:0] b);
    int s = 0;
    for (int e = 0; e < 3; e++) s += int'($signed(a[e*8 +: 8])) * int'($signed(b[e*8 +: 8]));
    return s;
  endfunction

  // core: one result register, updated on the edge that samples an image row
  always @(posedge i_clk) begin
    if (o_selec_K) begin
      kw[0] <= kw[1]; kw[1] <= kw[2]; kw[2] <= o_data_kernel;
    end
    if (o_selec_I) begin
      iw[0] <= iw[1]; iw[1] <= iw[2]; iw[2] <= o_data_img;
      i_conv_data <= 20'(dot3(kw[0], iw[1]) + dot3(kw[1], iw[2]) + dot3(kw[2], o_data_img));
    end
  end

  always @(posedge i_clk) begin
    #1;
    i_res_ready = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  always @(negedge i_clk) begin
    if (i_reset) begin
      k_es = 1'b0; i_es = 1'b0; k_ed = '0; i_ed = '0;
    end else begin
      if (o_selec_K !== k_es || o_data_kernel !== k_ed || o_selec_I !== i_es || o_data_img !== i_ed)
        sel_bad++;
      n_k    += int'(o_selec_K);
      n_i    += int'(o_selec_I);
      n_done += int'(o_done);
      n_kr   += int'(o_k_ready);
      if (o_res_valid === 1'b1 && i_res_ready === 1'b1) got_q.push_back(o_res_data);
      k_es = i_k_valid & o_k_ready;
      if (k_es) k_ed = i_k_data;
      i_es = i_img_valid & o_img_ready;
      if (i_es) i_ed = i_img_data;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DEF_M_ARRAY-1:0] pk(input int a0, input int a1, input int a2);
    return {8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [DEF_CONV_LEN-1:0] win_ref(input int j);
    int s = 0;
    for (int r = 0; r < 3; r++)
      for (int e = 0; e < 3; e++) s += kv[r][e] * iv[j+r][e];
    return 20'(s);
  endfunction

  task automatic set_lin(input int base);
    for (int r = 0; r < 3; r++) for (int e = 0; e < 3; e++) kv[r][e] = r + 1;
    for (int i = 0; i < IR; i++) for (int e = 0; e < 3; e++) iv[i][e] = base + i;
  endtask

  task automatic set_rand(input bit new_k);
    if (new_k) for (int r = 0; r < 3; r++) for (int e = 0; e < 3; e++) kv[r][e] = int'($urandom_range(0, 255)) - 128;
    for (int i = 0; i < IR; i++) for (int e = 0; e < 3; e++) iv[i][e] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic send(input bit img, input int r, input int gap);
    int n;
    n = 0;
    if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) tick();
    if (img) begin
      i_img_valid = 1'b1; i_img_data = pk(iv[r][0], iv[r][1], iv[r][2]);
      while (o_img_ready !== 1'b1 && n < LIM) begin tick(); n++; end
      chk("img_hs_wait", int'(n < LIM), 1);
    end else begin
      i_k_valid = 1'b1; i_k_data = pk(kv[r][0], kv[r][1], kv[r][2]);
      while (o_k_ready !== 1'b1 && n < LIM) begin tick(); n++; end
      chk("k_hs_wait", int'(n < LIM), 1);
    end
    tick();
    i_k_valid = 1'b0; i_img_valid = 1'b0;
  endtask

  task automatic run_frame(input bit reuse, input bit ld_k, input int gap, input bit stray, input bit hold);
    int k0, i0, d0, kr0, sb0, n;
    k0 = n_k; i0 = n_i; d0 = n_done; kr0 = n_kr; sb0 = sel_bad; n = 0;
    i_start = 1'b1; i_reuse_k = reuse; tick(); i_start = 1'b0; i_reuse_k = 1'b0;
    chk("busy_after_start", int'(o_busy), 1);
    chk("k_ready_after_start", int'(o_k_ready), int'(ld_k));
    if (ld_k) for (int r = 0; r < 3; r++) send(1'b0, r, gap);
    for (int r = 0; r < IR; r++) begin
      if (hold && r == IR - 1) begin
        i_img_valid = 1'b1; i_img_data = pk(iv[r][0], iv[r][1], iv[r][2]);
        repeat (4) tick();
        chk("bp_img_ready", int'(o_img_ready), 0);
        chk("bp_res_valid", int'(o_res_valid), 1);
        rmode = 0;
      end
      send(1'b1, r, gap);
      if (stray && r == 1) begin i_start = 1'b1; tick(); i_start = 1'b0; end
    end
    if (stray) begin i_start = 1'b1; tick(); i_start = 1'b0; end
    while (o_done !== 1'b1 && n < LIM) begin tick(); n++; end
    chk("done_wait", int'(n < LIM), 1);
    tick();
    chk("done_once", n_done - d0, 1);
    chk("selK_cycles", n_k - k0, ld_k ? 3 : 0);
    chk("selI_cycles", n_i - i0, IR);
    chk("sel_follow", sel_bad - sb0, 0);
    if (!ld_k) chk("no_k_ready", n_kr - kr0, 0);
    for (int j = 0; j < NW; j++) exp_q.push_back(win_ref(j));
  endtask

  task automatic drain_chk(input string tag);
    int n;
    n = 0;
    rmode = 0;
    while (o_res_valid !== 1'b0 && n < LIM) begin tick(); n++; end
    chk("drain_wait", int'(n < LIM), 1);
    tick();
    chk({tag, "_count"}, got_q.size() - gi, exp_q.size());
    for (int k = 0; k < exp_q.size() && gi + k < got_q.size(); k++)
      chk(tag, int'(got_q[gi+k]), int'(exp_q[k]));
    gi = got_q.size();
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_selK"}, int'(o_selec_K), 0);
    chk({tag, "_selI"}, int'(o_selec_I), 0);
    chk({tag, "_dk"}, int'(o_data_kernel), 0);
    chk({tag, "_di"}, int'(o_data_img), 0);
    chk({tag, "_kready"}, int'(o_k_ready), 0);
    chk({tag, "_iready"}, int'(o_img_ready), 0);
    chk({tag, "_rvalid"}, int'(o_res_valid), 0);
    chk({tag, "_rdata"}, int'(o_res_data), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_done"}, int'(o_done), 0);
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_reuse_k = 1'b0;
    i_k_valid = 1'b0; i_img_valid = 1'b0; i_k_data = '0; i_img_data = '0;
    #1;
    chk_all_zero("rst");
    repeat (3) tick();
    i_reset = 1'b0; rmode = 0;
    tick();

    set_lin(1);
    run_frame(1'b0, 1'b1, 0, 1'b0, 1'b0); drain_chk("t1_res");
    run_frame(1'b0, 1'b1, 1, 1'b0, 1'b0); drain_chk("t2_res");
    rmode = 1; tick(); tick();
    run_frame(1'b0, 1'b1, 0, 1'b0, 1'b1); drain_chk("t3_res");
    set_lin(2);
    run_frame(1'b1, 1'b0, 0, 1'b0, 1'b0); drain_chk("t4_res");

    set_lin(1);
    i_start = 1'b1; tick(); i_start = 1'b0;
    for (int r = 0; r < 3; r++) send(1'b0, r, 0);
    for (int r = 0; r < 3; r++) send(1'b1, r, 0);
    #2 i_reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    tick();
    i_reset = 1'b0;
    tick();
    run_frame(1'b1, 1'b1, 0, 1'b0, 1'b0); drain_chk("t5_res");

    run_frame(1'b0, 1'b1, 0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("t6_idle", int'(o_busy), 0);
    drain_chk("t6_res");

    for (int f = 0; f < 3; f++) begin
      set_rand(f != 1);
      rmode = 2;
      run_frame(f == 1, f != 1, 2, 1'b0, 1'b0);
      drain_chk("rand_res");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
